spi_ram_ctrl: RTL

Single-port 256 x 8 memory with a command decoder, sitting directly downstream of the SPI slave. It consumes the slave's 10-bit parallel words (`rx_data`/`rx_valid`), executes write-address, write-data, read-address and read-data commands, and returns read bytes on `tx_data`/`tx_valid`. The slave serialises those bytes on MISO.

---
 rtl/spi_ram_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/spi_ram_ctrl.sv
// 256 x 8 memory with a command decoder fed by the SPI slave's 10-bit words.
// Commands execute once per rising edge of rx_valid; read bytes are held on tx_data.
module spi_ram_ctrl #(
  parameter bit AUTO_INC  = 1'b0,
  parameter int MEM_DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       cmd_err
);

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  logic [7:0] mem [MEM_DEPTH];

  logic       rx_valid_q;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] rd_addr_q, rd_addr_d;
  logic       wr_ok_q, wr_ok_d;
  logic       rd_ok_q, rd_ok_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       cmd_err_q, cmd_err_d;
  logic       mem_we;
  logic       accept;
  logic [1:0] cmd;
  logic [7:0] payload;

  // A level held high over a frame is one command: only its first sampled cycle counts.
  assign accept  = rx_valid & ~rx_valid_q;
  assign cmd     = rx_data[9:8];
  assign payload = rx_data[7:0];

  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    wr_ok_d    = wr_ok_q;
    rd_ok_d    = rd_ok_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    cmd_err_d  = 1'b0;
    mem_we     = 1'b0;
    if (accept) begin
      // Any accepted command other than a successful read retires the held byte.
      tx_valid_d = 1'b0;
      case (cmd)
        CMD_WR_ADDR: begin
          wr_addr_d = payload;
          wr_ok_d   = 1'b1;
        end
        CMD_WR_DATA: begin
          if (wr_ok_q) begin
            mem_we = 1'b1;
            if (AUTO_INC) wr_addr_d = wr_addr_q + 8'd1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        CMD_RD_ADDR: begin
          rd_addr_d = payload;
          rd_ok_d   = 1'b1;
        end
        CMD_RD_DATA: begin
          if (rd_ok_q) begin
            tx_data_d  = mem[rd_addr_q];
            tx_valid_d = 1'b1;
            if (AUTO_INC) rd_addr_d = rd_addr_q + 8'd1;
          end else begin
            tx_data_d = 8'h00;
            cmd_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      wr_addr_q  <= 8'h00;
      rd_addr_q  <= 8'h00;
      wr_ok_q    <= 1'b0;
      rd_ok_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_ok_q    <= wr_ok_d;
      rd_ok_q    <= rd_ok_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  // Storage is deliberately outside reset so contents survive a mid-frame reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr_q] <= payload;
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign cmd_err  = cmd_err_q;

endmodule
